// File: rtl/rng_address_gen.sv
// Iterative restoring modulo: rng_address = which mod betterNeighborCount, one quotient bit per cycle.
// Optional macro RNG_ADDRESS_ZERO_ERR_EN adds the zero_count_err flag output.
module rng_address_gen #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start_rngAddress,
    input  logic [WORD_WIDTH-1:0] betterNeighborCount,
    input  logic [WORD_WIDTH-1:0] which,
    output logic [WORD_WIDTH-1:0] rng_address,
    output logic                  done_rng_address
`ifdef RNG_ADDRESS_ZERO_ERR_EN
    ,
    output logic                  zero_count_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [WORD_WIDTH-1:0] q, q_nxt;
    logic [WORD_WIDTH-1:0] d, d_nxt;
    logic [WORD_WIDTH-1:0] rem, rem_nxt;
    logic [CNT_WIDTH-1:0]  iter, iter_nxt;
    logic [WORD_WIDTH-1:0] addr_nxt;
    logic                  done_nxt;
    logic                  zerr, zerr_nxt;

    logic [WORD_WIDTH:0]   t;
    logic [WORD_WIDTH-1:0] diff;

    // q is shifted left each step, so its MSB is always q[iter] of the latched dividend
    assign t    = {rem, q[WORD_WIDTH-1]};
    assign diff = t[WORD_WIDTH-1:0] - d;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state            <= IDLE;
            q                <= '0;
            d                <= '0;
            rem              <= '0;
            iter             <= '0;
            rng_address      <= '0;
            done_rng_address <= 1'b0;
            zerr             <= 1'b0;
        end else begin
            state            <= state_nxt;
            q                <= q_nxt;
            d                <= d_nxt;
            rem              <= rem_nxt;
            iter             <= iter_nxt;
            rng_address      <= addr_nxt;
            done_rng_address <= done_nxt;
            zerr             <= zerr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        d_nxt     = d;
        rem_nxt   = rem;
        iter_nxt  = iter;
        addr_nxt  = rng_address;
        done_nxt  = done_rng_address;
        zerr_nxt  = zerr;
        if (en) begin
            case (state)
                IDLE: begin
                    done_nxt = 1'b0;
                    zerr_nxt = 1'b0;
                    if (start_rngAddress) begin
                        q_nxt    = which;
                        d_nxt    = betterNeighborCount;
                        rem_nxt  = '0;
                        iter_nxt = CNT_WIDTH'(WORD_WIDTH - 1);
                        if (betterNeighborCount == '0) begin
                            state_nxt = DONE;
                            addr_nxt  = '0;
                            done_nxt  = 1'b1;
                            zerr_nxt  = 1'b1;
                        end else begin
                            state_nxt = DIV;
                        end
                    end
                end
                DIV: begin
                    rem_nxt = (t >= {1'b0, d}) ? diff : t[WORD_WIDTH-1:0];
                    q_nxt   = {q[WORD_WIDTH-2:0], 1'b0};
                    if (iter == '0) begin
                        addr_nxt  = rem_nxt;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        iter_nxt = iter - CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (!start_rngAddress) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b0;
                        zerr_nxt  = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b0;
                    zerr_nxt  = 1'b0;
                end
            endcase
        end
    end

`ifdef RNG_ADDRESS_ZERO_ERR_EN
    assign zero_count_err = zerr;
`endif

endmodule

// File: tb/tb_rng_address_gen.sv
// Directed bench for rng_address_gen: scoreboard of expected remainders popped when done rises.
module tb_rng_address_gen;

    logic        clock = 1'b0;
    logic        nrst;
    logic        en;
    logic        start_rngAddress;
    logic [15:0] betterNeighborCount;
    logic [15:0] which;
    logic [15:0] rng_address;
    logic        done_rng_address;
`ifdef RNG_ADDRESS_ZERO_ERR_EN
    logic        zero_count_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    always #5 clock = ~clock;

    rng_address_gen #(
        .WORD_WIDTH(16),
        .CNT_WIDTH (5)
    ) dut (
        .clock              (clock),
        .nrst               (nrst),
        .en                 (en),
        .start_rngAddress   (start_rngAddress),
        .betterNeighborCount(betterNeighborCount),
        .which              (which),
        .rng_address        (rng_address),
        .done_rng_address   (done_rng_address)
`ifdef RNG_ADDRESS_ZERO_ERR_EN
        ,
        .zero_count_err     (zero_count_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Entered #1 after edge 'base'; waits (bounded) for done and checks latency plus scoreboard head.
    task automatic wait_done(input string tag, input int base, input int exp_lat);
        int n = base;
        bit seen = 1'b0;
        logic [15:0] e;
        while (n < base + 40) begin
            if (done_rng_address === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
            n++;
        end
        chk({tag, "_latency"}, seen ? n : -1, exp_lat);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rng"}, rng_address, e);
        end
    endtask

    // Full handshake; entered and left #1 after a posedge.
    task automatic run_req(input string tag, input logic [15:0] w, input logic [15:0] c,
                           input logic [15:0] exp, input int exp_lat, input int hold_extra);
        which = w;
        betterNeighborCount = c;
        start_rngAddress = 1'b1;
        exp_q.push_back(exp);
        tick();
        wait_done(tag, 0, exp_lat);
`ifdef RNG_ADDRESS_ZERO_ERR_EN
        chk({tag, "_zerr_done"}, zero_count_err, (c == 16'd0) ? 1 : 0);
`endif
        for (int i = 0; i < hold_extra; i++) begin
            tick();
            chk({tag, "_hold_done"}, done_rng_address, 1);
            chk({tag, "_hold_rng"}, rng_address, exp);
        end
        start_rngAddress = 1'b0;
        tick();
        chk({tag, "_done_drop"}, done_rng_address, 0);
        chk({tag, "_rng_keep"}, rng_address, exp);
`ifdef RNG_ADDRESS_ZERO_ERR_EN
        chk({tag, "_zerr_idle"}, zero_count_err, 0);
`endif
    endtask

    initial begin
        int spurious;
        nrst = 1'b0;
        en = 1'b1;
        start_rngAddress = 1'b0;
        which = '0;
        betterNeighborCount = '0;
        #2;
        chk("reset_done", done_rng_address, 0);
        chk("reset_rng", rng_address, 0);
        tick();
        tick();
        nrst = 1'b1;
        tick();
        chk("post_reset_done", done_rng_address, 0);
        chk("post_reset_rng", rng_address, 0);

        run_req("m13_5", 16'd13, 16'd5, 16'd3, 16, 3);
        run_req("m7_10", 16'd7, 16'd10, 16'd7, 16, 0);
        run_req("mffff_3", 16'hFFFF, 16'd3, 16'd0, 16, 0);
        run_req("m100_7", 16'd100, 16'd7, 16'd2, 16, 0);
        run_req("m9_0", 16'd9, 16'd0, 16'd0, 0, 1);
        run_req("mbeef_1", 16'hBEEF, 16'd1, 16'd0, 16, 0);
        run_req("mffff_ffff", 16'hFFFF, 16'hFFFF, 16'd0, 16, 0);
        run_req("m1000_999", 16'd1000, 16'd999, 16'd1, 16, 0);

        // en low for 4 cycles mid-DIV, operands scrambled meanwhile
        which = 16'd13;
        betterNeighborCount = 16'd5;
        start_rngAddress = 1'b1;
        exp_q.push_back(16'd3);
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("en_mid_done", done_rng_address, 0);
        en = 1'b0;
        which = 16'h1234;
        betterNeighborCount = 16'd9;
        for (int i = 0; i < 4; i++) tick();
        en = 1'b1;
        wait_done("en_stall", 9, 20);
        start_rngAddress = 1'b0;
        tick();
        chk("en_stall_done_drop", done_rng_address, 0);

        // Reset mid-DIV aborts; no done afterwards
        which = 16'd13;
        betterNeighborCount = 16'd5;
        start_rngAddress = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        nrst = 1'b0;
        #1;
        chk("abort_done", done_rng_address, 0);
        chk("abort_rng", rng_address, 0);
        start_rngAddress = 1'b0;
        tick();
        nrst = 1'b1;
        spurious = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (done_rng_address !== 1'b0) spurious++;
        end
        chk("abort_no_done", spurious, 0);
        run_req("fresh_100_7", 16'd100, 16'd7, 16'd2, 16, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
